// File: rtl/cbs_mac_accum_if.sv
// Beat/result bus for cbs_mac_accum: window+weights in, saturated channel sum out.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface cbs_mac_accum_if #(
    parameter int NUM_CH = 3,
    parameter int K      = 3,
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 8,
    parameter int OUT_W  = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [K*K*PIX_W-1:0]   in_pix;
    logic [K*K*WGT_W-1:0]   in_wgt;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic                   out_sat;
    logic [CH_W-1:0]        ch_idx;

    modport slave (
        input  in_valid, in_pix, in_wgt, out_ready,
        output in_ready, out_valid, out_data, out_sat, ch_idx
    );

    modport master (
        output in_valid, in_pix, in_wgt, out_ready,
        input  in_ready, out_valid, out_data, out_sat, ch_idx
    );
endinterface

// File: rtl/cbs_mac_accum.sv
// Sequential K*K MAC over NUM_CH channel beats, one saturated pixel per NUM_CH beats.
// Optional CBS_LEAKY_ACT_EN: negative saturated results are scaled by 1/8 (arithmetic shift).
module cbs_mac_accum #(
    parameter int NUM_CH = 3,
    parameter int K      = 3,
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 8,
    parameter int OUT_W  = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    cbs_mac_accum_if.slave  bus
);
    localparam int TAPS  = K * K;
    localparam int PW    = PIX_W + WGT_W;
    localparam int DOT_W = PW + $clog2(TAPS);
    localparam int ACC_W = DOT_W + $clog2(NUM_CH) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CH_W-1:0]         ch_idx_q, ch_idx_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [PW-1:0]    prod [TAPS];
    logic signed [DOT_W-1:0] dot;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [CMP_W-1:0] acc_ext;
    logic signed [OUT_W-1:0] clip_val;
    logic signed [OUT_W-1:0] act_val;
    logic                    clip;
    logic                    in_ready;
    logic                    accept;
    logic                    last;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign prod[gi] = PW'($signed(bus.in_pix[gi*PIX_W +: PIX_W]))
                            * PW'($signed(bus.in_wgt[gi*WGT_W +: WGT_W]));
        end
    endgenerate

    always_comb begin
        dot = '0;
        for (int t = 0; t < TAPS; t++) begin
            dot = dot + DOT_W'(prod[t]);
        end
    end

    // A stalled result blocks every beat, not just the one that would overwrite it.
    assign in_ready = !out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;
    assign last     = (ch_idx_q == CH_W'(NUM_CH - 1));

    // The first channel of a pixel restarts the sum instead of adding to stale state.
    assign acc_base = (ch_idx_q == '0) ? '0 : acc_q;
    assign acc_sum  = acc_base + ACC_W'(dot);
    assign acc_ext  = CMP_W'(acc_sum);

    always_comb begin
        clip_val = acc_ext[OUT_W-1:0];
        clip     = 1'b0;
        if (acc_ext > SAT_MAX) begin
            clip_val = {1'b0, {(OUT_W-1){1'b1}}};
            clip     = 1'b1;
        end else if (acc_ext < SAT_MIN) begin
            clip_val = {1'b1, {(OUT_W-1){1'b0}}};
            clip     = 1'b1;
        end
    end

`ifdef CBS_LEAKY_ACT_EN
    assign act_val = clip_val[OUT_W-1] ? (clip_val >>> 3) : clip_val;
`else
    assign act_val = clip_val;
`endif

    always_comb begin
        acc_d       = acc_q;
        ch_idx_d    = ch_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            acc_d    = acc_sum;
            ch_idx_d = last ? '0 : ch_idx_q + CH_W'(1);
            if (last) begin
                out_valid_d = 1'b1;
                out_data_d  = act_val;
                out_sat_d   = clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ch_idx_q    <= ch_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.ch_idx    = ch_idx_q;
endmodule
